// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// seg_scan_mux : multiplexed 7-segment digit scanner with frame snapshot,
//                anti-ghost blanking and leading-zero suppression. Rev 1.0
// ============================================================================
module seg_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  seg_blank,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] C_IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_snap;
    logic [DIGITS-1:0]      r_snap_dp;

    logic [CW-1:0]          w_cnt_nx;
    logic [IW-1:0]          w_idx_nx;
    logic [4*DIGITS-1:0]    w_snap_nx;
    logic [DIGITS-1:0]      w_snap_dp_nx;
    logic                   w_wrap;
    logic                   w_in_blank;
    logic [3:0]             w_nibble;
    logic [DIGITS-1:0]      w_sel;
    logic                   w_dp;
    logic                   w_lz_hide;
    logic                   w_upper_zero;

    // Next state while scanning; the idle/reset path is handled in the register block.
    always_comb begin
        w_cnt_nx     = r_cnt + 1'b1;
        w_idx_nx     = r_idx;
        w_snap_nx    = r_snap;
        w_snap_dp_nx = r_snap_dp;
        w_wrap       = 1'b0;
        if (r_cnt == C_CNT_MAX) begin
            w_cnt_nx = '0;
            if (r_idx == C_IDX_MAX) begin
                w_idx_nx     = '0;
                w_wrap       = 1'b1;
                w_snap_nx    = data;
                w_snap_dp_nx = dp_in;
            end else begin
                w_idx_nx = r_idx + 1'b1;
            end
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_in_blank = 1'b0;
        end else begin : g_blank
            assign w_in_blank = (w_cnt_nx < CW'(BLANK_CYC));
        end
    endgenerate

    // Decode from post-edge state; the downward walk tracks "nibbles i..top all zero".
    always_comb begin
        w_nibble     = 4'h0;
        w_sel        = '0;
        w_dp         = 1'b0;
        w_lz_hide    = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (w_snap_nx[4*i +: 4] != 4'h0) begin
                w_upper_zero = 1'b0;
            end
            if (int'(w_idx_nx) == i) begin
                w_nibble  = w_snap_nx[4*i +: 4];
                w_sel[i]  = ~w_in_blank;
                w_dp      = w_snap_dp_nx[i] & ~w_in_blank;
                w_lz_hide = lz_en & (i != 0) & w_upper_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_snap     <= data;
            r_snap_dp  <= dp_in;
            nibble     <= 4'h0;
            digit_sel  <= '0;
            seg_blank  <= 1'b1;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_snap     <= w_snap_nx;
            r_snap_dp  <= w_snap_dp_nx;
            nibble     <= w_nibble;
            digit_sel  <= w_sel;
            seg_blank  <= w_in_blank | w_lz_hide;
            dp         <= w_dp;
            frame_tick <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_mux : directed self-checking bench, DIGITS=4 CLK_DIV=4 BLANK_CYC=1.
// Rev 1.0
// ============================================================================
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  nibble;
    logic [3:0]  digit_sel;
    logic        seg_blank;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg_scan_mux #(
        .DIGITS    (4),
        .CLK_DIV   (4),
        .BLANK_CYC (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .nibble     (nibble),
        .digit_sel  (digit_sel),
        .seg_blank  (seg_blank),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs packed as {digit_sel, nibble, seg_blank, dp, frame_tick}.
    function automatic logic [10:0] obs_vec();
        return {digit_sel, nibble, seg_blank, dp, frame_tick};
    endfunction

    // Expected outputs for scan edge k after a restart, from the frame's latched data.
    function automatic logic [10:0] expect_at(int k, logic [15:0] sd, logic [3:0] sdp, logic lz);
        int         idx;
        int         cnt;
        logic [3:0] sel;
        logic       zero_above;
        logic       hide;
        logic       blank;
        idx = (k / 4) % 4;
        cnt = k % 4;
        sel = (cnt >= 1) ? 4'(1 << idx) : 4'b0000;
        zero_above = 1'b1;
        for (int j = idx; j < 4; j++) begin
            if (sd[j*4 +: 4] != 4'h0) zero_above = 1'b0;
        end
        hide  = lz && (idx != 0) && zero_above;
        blank = (cnt < 1) || hide;
        return {sel, sd[idx*4 +: 4], blank, sdp[idx] && (cnt >= 1), (k % 16) == 0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [10:0] got, logic [10:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s observed sel/nib/blk/dp/tick=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic scan_run(string tag, int k0, int k1, logic [15:0] sd, logic [3:0] sdp, logic lz);
        for (int k = k0; k <= k1; k++) begin
            step();
            chk($sformatf("%s_k%0d", tag, k), obs_vec(), expect_at(k, sd, sdp, lz));
        end
    endtask

    localparam logic [10:0] C_IDLE = {4'b0000, 4'h0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        data  = 16'h0000;
        dp_in = 4'b0000;
        lz_en = 1'b0;

        // Reset held for three edges, then released with scanning disabled.
        for (int i = 0; i < 3; i++) step();
        chk("reset", obs_vec(), C_IDLE);
        rst_n = 1'b1;
        data  = 16'h1234;
        dp_in = 4'b0100;
        step();
        chk("idle_en0_a", obs_vec(), C_IDLE);
        step();
        chk("idle_en0_b", obs_vec(), C_IDLE);

        // Scan plus mid-frame data change: the frame in progress keeps 1234.
        en = 1'b1;
        step();
        chk("scan_e1", obs_vec(), {4'b0001, 4'h4, 1'b0, 1'b0, 1'b0});
        scan_run("scan", 2, 6, 16'h1234, 4'b0100, 1'b0);
        data = 16'hABCD;
        scan_run("snap_old", 7, 15, 16'h1234, 4'b0100, 1'b0);
        step();
        chk("snap_wrap_e16", obs_vec(), {4'b0000, 4'hD, 1'b1, 1'b0, 1'b1});
        scan_run("snap_new", 17, 32, 16'hABCD, 4'b0100, 1'b0);

        // Leading-zero suppression on 0050.
        en    = 1'b0;
        data  = 16'h0050;
        dp_in = 4'b0000;
        lz_en = 1'b1;
        step();
        chk("lz_idle", obs_vec(), C_IDLE);
        en = 1'b1;
        scan_run("lz50", 1, 16, 16'h0050, 4'b0000, 1'b1);

        // All-zero value: only digit 0 remains visible.
        en   = 1'b0;
        data = 16'h0000;
        step();
        en = 1'b1;
        scan_run("lz00", 1, 16, 16'h0000, 4'b0000, 1'b1);
        step();
        chk("lz00_d0_lit", obs_vec(), {4'b0001, 4'h0, 1'b0, 1'b0, 1'b0});

        // Enable drop at idx=2 cnt=2, then restart with freshly captured data.
        lz_en = 1'b0;
        en    = 1'b0;
        data  = 16'h1234;
        dp_in = 4'b0100;
        step();
        en = 1'b1;
        scan_run("pre_drop", 1, 10, 16'h1234, 4'b0100, 1'b0);
        en    = 1'b0;
        data  = 16'h5678;
        step();
        chk("en_drop", obs_vec(), C_IDLE);
        en = 1'b1;
        step();
        chk("en_restart", obs_vec(), {4'b0001, 4'h8, 1'b0, 1'b0, 1'b0});

        // Reset pulse during digit 3.
        scan_run("pre_rst", 2, 13, 16'h5678, 4'b0100, 1'b0);
        rst_n = 1'b0;
        step();
        chk("rst_mid", obs_vec(), C_IDLE);
        rst_n = 1'b1;
        scan_run("post_rst", 1, 16, 16'h5678, 4'b0100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
